ifetch_unit: RTL

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit_if.sv | 30 +++
 rtl/ifetch_unit.sv | 115 +++++++++++
 2 files changed

// File: rtl/ifetch_unit_if.sv
// Instruction-fetch bus bundle: PC request channel, instruction-memory port,
// flush and the decoded-instruction output channel.
// The fetch unit itself connects through the slave modport; the environment
// (PC unit, memory, decode) drives through the master modport.
interface ifetch_unit_if #(
  parameter int ADDR_W = 14
);
  logic [31:0]       pc_in;
  logic              pc_valid;
  logic              pc_ready;
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              flush;
  logic [31:0]       inst_out;
  logic [31:0]       inst_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic              fetch_err;

  modport master (
    output pc_in, pc_valid, imem_rdata, flush, inst_ready,
    input  pc_ready, imem_en, imem_addr, inst_out, inst_pc, inst_valid, fetch_err
  );

  modport slave (
    input  pc_in, pc_valid, imem_rdata, flush, inst_ready,
    output pc_ready, imem_en, imem_addr, inst_out, inst_pc, inst_valid, fetch_err
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: accepts PCs, issues synchronous reads to instruction
// memory, and queues the returned words with their PCs in a DEPTH-entry FIFO
// that feeds decode. A PC accepted in cycle N is visible at the head in N+2.
// Optional feature: define IFETCH_MISALIGN_CHECK_EN to turn misaligned PCs
// into nop entries flagged by a one-cycle fetch_err pulse.
// DEPTH must be a power of two (>= 2) so the pointers wrap for free.
module ifetch_unit #(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 4
) (
  input logic          clock,
  input logic          reset,
  ifetch_unit_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             inflight;
  logic [31:0]      pc_q;
  logic [31:0]      buf_inst [DEPTH];
  logic [31:0]      buf_pc   [DEPTH];

  logic [CNT_W:0]   used;
  logic             accept;
  logic             push;
  logic             pop;
  logic [31:0]      wr_inst;

  // Slots already committed: buffered entries plus the read still in flight,
  // so a returning word always has a free entry waiting for it.
  assign used   = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign bus.pc_ready = !reset && !bus.flush && (used < DEPTH_C);
  assign accept = bus.pc_valid && bus.pc_ready;

  // Memory address follows pc_in every cycle; only imem_en qualifies it.
  assign bus.imem_addr = bus.pc_in[ADDR_W+1:2];

  // Returned data is written the cycle after issue unless flush kills it.
  assign push = inflight && !bus.flush;
  assign pop  = (count != '0) && bus.inst_ready && !bus.flush;

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic misaligned;
  logic mis_q;

  assign misaligned    = bus.pc_in[1:0] != 2'b00;
  // A misaligned request still takes a slot but never touches memory.
  assign bus.imem_en   = accept && !misaligned;
  assign wr_inst       = mis_q ? 32'h0000_0000 : bus.imem_rdata;
  assign bus.fetch_err = push && mis_q;
`else
  assign bus.imem_en   = accept;
  assign wr_inst       = bus.imem_rdata;
  assign bus.fetch_err = 1'b0;
`endif

  assign bus.inst_valid = count != '0;
  assign bus.inst_out   = buf_inst[head];
  assign bus.inst_pc    = buf_pc[head];

  // Pointer, occupancy and in-flight tracking; flush wipes everything.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= 1'b0;
      pc_q     <= 32'h0;
`ifdef IFETCH_MISALIGN_CHECK_EN
      mis_q    <= 1'b0;
`endif
    end else if (bus.flush) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= accept;
      if (accept) begin
        pc_q <= bus.pc_in;
`ifdef IFETCH_MISALIGN_CHECK_EN
        mis_q <= misaligned;
`endif
      end
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Buffer storage: tail entry captures the returning word and its PC.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_inst[i] <= 32'h0;
        buf_pc[i]   <= 32'h0;
      end
    end else if (push) begin
      buf_inst[tail] <= wr_inst;
      buf_pc[tail]   <= pc_q;
    end
  end

  // Occupancy plus outstanding read never exceeds the buffer size.
  a_no_overflow: assert property (@(posedge clock) disable iff (reset) used <= DEPTH_C);

endmodule
